// File: rtl/cu_mem_arbiter_pkg.sv
// Shared definitions for the L1-to-L2 memory arbiter: arbitration mode
// encodings and the derived port-index / tag width helpers.
package cu_mem_arbiter_pkg;

   localparam int ARB_RR    = 0;  // rotating priority
   localparam int ARB_FIXED = 1;  // lowest index wins

   // Bits needed to name a source port; at least one bit even for tiny N.
   function automatic int calc_pw(input int num_ports);
      return (num_ports > 1) ? $clog2(num_ports) : 1;
   endfunction

   // Upstream tag widened by the source port index in the MSBs.
   function automatic int calc_tag_out_width(input int tag_in_width, input int num_ports);
      return tag_in_width + calc_pw(num_ports);
   endfunction

endpackage

// File: rtl/cu_mem_arbiter_rr_arbiter.sv
// Single-grant arbiter: picks one eligible requester per cycle, either by
// rotating priority starting at rr_ptr or by fixed lowest-index priority.
module rr_arbiter
   import cu_mem_arbiter_pkg::*;
#(
   parameter int  NUM_PORTS = 4,
   parameter int  ARB_MODE  = ARB_RR,
   localparam int PW        = calc_pw(NUM_PORTS)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [NUM_PORTS-1:0] eligible_i,
   input  logic                 grant_en_i,
   output logic                 grant_valid_o,
   output logic [NUM_PORTS-1:0] grant_oh_o,
   output logic [PW-1:0]        grant_idx_o
);

   logic [PW-1:0] ptr_q, ptr_d;

   // Search from the start point with wrap-around; advance pointer past winner.
   always_comb begin
      logic          found;
      int            start;
      int            j;
      logic [PW-1:0] j_idx;
      found       = 1'b0;
      start       = 0;
      j           = 0;
      j_idx       = '0;
      grant_oh_o  = '0;
      grant_idx_o = '0;
      start = (ARB_MODE == ARB_FIXED) ? 0 : int'(ptr_q);
      for (int off = 0; off < NUM_PORTS; off++) begin
         j = start + off;
         if (j >= NUM_PORTS) j = j - NUM_PORTS;
         j_idx = PW'(j);
         if (!found && eligible_i[j_idx]) begin
            found              = 1'b1;
            grant_oh_o[j_idx]  = 1'b1;
            grant_idx_o        = j_idx;
         end
      end
      grant_valid_o = found;
      ptr_d = ptr_q;
      if (grant_en_i && found) begin
         ptr_d = (grant_idx_o == PW'(NUM_PORTS - 1)) ? '0 : grant_idx_o + PW'(1);
      end
   end

   // Rotating priority pointer; only moves when a grant is actually taken.
   always_ff @(posedge clk_i) begin
      if (rst_i) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

endmodule

// File: rtl/cu_mem_arbiter.sv
// N-to-1 L2 request arbiter with per-port read credit limiting and
// tag-indexed combinational response routing back to the issuing port.
module cu_mem_arbiter
   import cu_mem_arbiter_pkg::*;
#(
   parameter int  NUM_PORTS       = 4,
   parameter int  ADDR_WIDTH      = 26,
   parameter int  DATA_WIDTH      = 512,
   parameter int  TAG_IN_WIDTH    = 8,
   parameter int  MAX_OUTSTANDING = 8,
   parameter int  ARB_MODE        = ARB_RR,
   localparam int PW              = calc_pw(NUM_PORTS),
   localparam int TAG_OUT_WIDTH   = calc_tag_out_width(TAG_IN_WIDTH, NUM_PORTS),
   localparam int BE_WIDTH        = DATA_WIDTH / 8
) (
   input  logic                                    clk_i,
   input  logic                                    rst_i,
   input  logic [NUM_PORTS-1:0]                    in_req_valid_i,
   input  logic [NUM_PORTS-1:0]                    in_req_rw_i,
   input  logic [NUM_PORTS-1:0][BE_WIDTH-1:0]      in_req_byteen_i,
   input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]    in_req_addr_i,
   input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]    in_req_data_i,
   input  logic [NUM_PORTS-1:0][TAG_IN_WIDTH-1:0]  in_req_tag_i,
   output logic [NUM_PORTS-1:0]                    in_req_ready_o,
   output logic [NUM_PORTS-1:0]                    in_rsp_valid_o,
   output logic [DATA_WIDTH-1:0]                   in_rsp_data_o,
   output logic [TAG_IN_WIDTH-1:0]                 in_rsp_tag_o,
   input  logic [NUM_PORTS-1:0]                    in_rsp_ready_i,
   output logic                                    out_req_valid_o,
   output logic                                    out_req_rw_o,
   output logic [BE_WIDTH-1:0]                     out_req_byteen_o,
   output logic [ADDR_WIDTH-1:0]                   out_req_addr_o,
   output logic [DATA_WIDTH-1:0]                   out_req_data_o,
   output logic [TAG_OUT_WIDTH-1:0]                out_req_tag_o,
   input  logic                                    out_req_ready_i,
   input  logic                                    out_rsp_valid_i,
   input  logic [DATA_WIDTH-1:0]                   out_rsp_data_i,
   input  logic [TAG_OUT_WIDTH-1:0]                out_rsp_tag_i,
   output logic                                    out_rsp_ready_o,
   output logic                                    err_o
);

   localparam int CW = $clog2(MAX_OUTSTANDING + 1);

   logic [NUM_PORTS-1:0]     eligible;
   logic [NUM_PORTS-1:0]     grant_oh;
   logic [PW-1:0]            grant_idx;
   logic                     grant_valid;
   logic                     grant_en;
   logic                     grant_fire;
   logic [CW-1:0]            outstanding_q [NUM_PORTS];
   logic [CW-1:0]            outstanding_d [NUM_PORTS];
   logic                     out_valid_q, out_valid_d;
   logic                     out_rw_q, out_rw_d;
   logic [BE_WIDTH-1:0]      out_byteen_q, out_byteen_d;
   logic [ADDR_WIDTH-1:0]    out_addr_q, out_addr_d;
   logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
   logic [TAG_OUT_WIDTH-1:0] out_tag_q, out_tag_d;
   logic                     err_q, err_d;
   logic [PW-1:0]            rsp_idx;
   logic                     rsp_idx_legal;

   // Reads need a free credit; writes never generate a response, so always pass.
   for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_elig
      assign eligible[gi] = in_req_valid_i[gi] &
                            (in_req_rw_i[gi] | (outstanding_q[gi] < CW'(MAX_OUTSTANDING)));
   end

   rr_arbiter #(
      .NUM_PORTS (NUM_PORTS),
      .ARB_MODE  (ARB_MODE)
   ) u_arb (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .eligible_i    (eligible),
      .grant_en_i    (grant_en),
      .grant_valid_o (grant_valid),
      .grant_oh_o    (grant_oh),
      .grant_idx_o   (grant_idx)
   );

   // Accept a new request only when the output slot is free or draining now.
   assign grant_en       = !rst_i && (!out_valid_q || out_req_ready_i);
   assign grant_fire     = grant_en && grant_valid;
   assign in_req_ready_o = grant_en ? grant_oh : '0;

   // Output slot: load winner's payload with port index prepended to its tag.
   always_comb begin
      out_valid_d  = out_valid_q;
      out_rw_d     = out_rw_q;
      out_byteen_d = out_byteen_q;
      out_addr_d   = out_addr_q;
      out_data_d   = out_data_q;
      out_tag_d    = out_tag_q;
      if (out_valid_q && out_req_ready_i) out_valid_d = 1'b0;
      if (grant_fire) begin
         out_valid_d = 1'b1;
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant_oh[p]) begin
               out_rw_d     = in_req_rw_i[p];
               out_byteen_d = in_req_byteen_i[p];
               out_addr_d   = in_req_addr_i[p];
               out_data_d   = in_req_data_i[p];
               out_tag_d    = {grant_idx, in_req_tag_i[p]};
            end
         end
      end
   end

   // Response demux by tag MSBs; unknown index is swallowed and flagged.
   always_comb begin
      rsp_idx         = out_rsp_tag_i[TAG_OUT_WIDTH-1 -: PW];
      rsp_idx_legal   = 1'b0;
      out_rsp_ready_o = 1'b1;
      in_rsp_valid_o  = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (rsp_idx == PW'(p)) begin
            rsp_idx_legal     = 1'b1;
            in_rsp_valid_o[p] = out_rsp_valid_i;
            out_rsp_ready_o   = in_rsp_ready_i[p];
         end
      end
      err_d = err_q | (out_rsp_valid_i & !rsp_idx_legal);
   end

   assign in_rsp_data_o = out_rsp_data_i;
   assign in_rsp_tag_o  = out_rsp_tag_i[TAG_IN_WIDTH-1:0];

   // Credit counters: +1 on read grant, -1 on response handshake, saturating.
   always_comb begin
      logic inc;
      logic dec;
      for (int p = 0; p < NUM_PORTS; p++) begin
         inc = grant_fire & grant_oh[p] & !in_req_rw_i[p];
         dec = in_rsp_valid_o[p] & in_rsp_ready_i[p] & (outstanding_q[p] != '0);
         outstanding_d[p] = outstanding_q[p];
         if (inc && !dec)      outstanding_d[p] = outstanding_q[p] + CW'(1);
         else if (!inc && dec) outstanding_d[p] = outstanding_q[p] - CW'(1);
      end
   end

   // Control state with reset: slot valid, credits, sticky error.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
         for (int p = 0; p < NUM_PORTS; p++) outstanding_q[p] <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         err_q       <= err_d;
         for (int p = 0; p < NUM_PORTS; p++) outstanding_q[p] <= outstanding_d[p];
      end
   end

   // Payload needs no reset: it is only observed while out_valid_q is set.
   always_ff @(posedge clk_i) begin
      out_rw_q     <= out_rw_d;
      out_byteen_q <= out_byteen_d;
      out_addr_q   <= out_addr_d;
      out_data_q   <= out_data_d;
      out_tag_q    <= out_tag_d;
   end

   assign out_req_valid_o  = out_valid_q;
   assign out_req_rw_o     = out_rw_q;
   assign out_req_byteen_o = out_byteen_q;
   assign out_req_addr_o   = out_addr_q;
   assign out_req_data_o   = out_data_q;
   assign out_req_tag_o    = out_tag_q;
   assign err_o            = err_q;

endmodule

// File: tb/tb_cu_mem_arbiter.sv
// Scoreboard bench: DUT A (4 ports, round-robin, 8 credits) and
// DUT B (3 ports, fixed priority) for the illegal-index error path.
module tb_cu_mem_arbiter;

   localparam int AW = 16;
   localparam int DW = 32;
   localparam int TW = 8;
   localparam int BW = DW / 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // DUT A
   logic [3:0]          a_req_valid, a_req_rw, a_req_ready, a_rsp_valid, a_rsp_ready;
   logic [3:0][BW-1:0]  a_req_byteen;
   logic [3:0][AW-1:0]  a_req_addr;
   logic [3:0][DW-1:0]  a_req_data;
   logic [3:0][TW-1:0]  a_req_tag;
   logic [DW-1:0]       a_rsp_data;
   logic [TW-1:0]       a_rsp_tag;
   logic                a_out_valid, a_out_rw, a_out_ready;
   logic [BW-1:0]       a_out_byteen;
   logic [AW-1:0]       a_out_addr;
   logic [DW-1:0]       a_out_data;
   logic [TW+1:0]       a_out_tag;
   logic                a_l2_rsp_valid, a_l2_rsp_ready, a_err;
   logic [DW-1:0]       a_l2_rsp_data;
   logic [TW+1:0]       a_l2_rsp_tag;

   // DUT B
   logic [2:0]          b_req_valid, b_req_rw, b_req_ready, b_rsp_valid, b_rsp_ready;
   logic [2:0][BW-1:0]  b_req_byteen;
   logic [2:0][AW-1:0]  b_req_addr;
   logic [2:0][DW-1:0]  b_req_data;
   logic [2:0][TW-1:0]  b_req_tag;
   logic [DW-1:0]       b_rsp_data;
   logic [TW-1:0]       b_rsp_tag;
   logic                b_out_valid, b_out_rw, b_out_ready;
   logic [BW-1:0]       b_out_byteen;
   logic [AW-1:0]       b_out_addr;
   logic [DW-1:0]       b_out_data;
   logic [TW+1:0]       b_out_tag;
   logic                b_l2_rsp_valid, b_l2_rsp_ready, b_err;
   logic [DW-1:0]       b_l2_rsp_data;
   logic [TW+1:0]       b_l2_rsp_tag;

   cu_mem_arbiter #(
      .NUM_PORTS(4), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_IN_WIDTH(TW),
      .MAX_OUTSTANDING(8), .ARB_MODE(0)
   ) dut_a (
      .clk_i(clk), .rst_i(rst),
      .in_req_valid_i(a_req_valid), .in_req_rw_i(a_req_rw), .in_req_byteen_i(a_req_byteen),
      .in_req_addr_i(a_req_addr), .in_req_data_i(a_req_data), .in_req_tag_i(a_req_tag),
      .in_req_ready_o(a_req_ready), .in_rsp_valid_o(a_rsp_valid), .in_rsp_data_o(a_rsp_data),
      .in_rsp_tag_o(a_rsp_tag), .in_rsp_ready_i(a_rsp_ready),
      .out_req_valid_o(a_out_valid), .out_req_rw_o(a_out_rw), .out_req_byteen_o(a_out_byteen),
      .out_req_addr_o(a_out_addr), .out_req_data_o(a_out_data), .out_req_tag_o(a_out_tag),
      .out_req_ready_i(a_out_ready), .out_rsp_valid_i(a_l2_rsp_valid),
      .out_rsp_data_i(a_l2_rsp_data), .out_rsp_tag_i(a_l2_rsp_tag),
      .out_rsp_ready_o(a_l2_rsp_ready), .err_o(a_err)
   );

   cu_mem_arbiter #(
      .NUM_PORTS(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_IN_WIDTH(TW),
      .MAX_OUTSTANDING(2), .ARB_MODE(1)
   ) dut_b (
      .clk_i(clk), .rst_i(rst),
      .in_req_valid_i(b_req_valid), .in_req_rw_i(b_req_rw), .in_req_byteen_i(b_req_byteen),
      .in_req_addr_i(b_req_addr), .in_req_data_i(b_req_data), .in_req_tag_i(b_req_tag),
      .in_req_ready_o(b_req_ready), .in_rsp_valid_o(b_rsp_valid), .in_rsp_data_o(b_rsp_data),
      .in_rsp_tag_o(b_rsp_tag), .in_rsp_ready_i(b_rsp_ready),
      .out_req_valid_o(b_out_valid), .out_req_rw_o(b_out_rw), .out_req_byteen_o(b_out_byteen),
      .out_req_addr_o(b_out_addr), .out_req_data_o(b_out_data), .out_req_tag_o(b_out_tag),
      .out_req_ready_i(b_out_ready), .out_rsp_valid_i(b_l2_rsp_valid),
      .out_rsp_data_i(b_l2_rsp_data), .out_rsp_tag_i(b_l2_rsp_tag),
      .out_rsp_ready_o(b_l2_rsp_ready), .err_o(b_err)
   );

   typedef struct packed {
      logic          rw;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [TW+1:0] tag;
   } req_t;

   typedef struct packed {
      logic [1:0]    port;
      logic [TW-1:0] tag;
      logic [DW-1:0] data;
   } rsp_t;

   req_t req_q[$];
   rsp_t rsp_q[$];
   int   vectors    = 0;
   int   miscompares = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   // Hand-chosen per-port payload constants for DUT A.
   function automatic req_t exp_req(input int p, input logic rw);
      req_t r;
      r.rw   = rw;
      r.addr = 16'hA000 + 16'(p);
      r.data = 32'hD0D0_0000 + 32'(p);
      r.tag  = {2'(p), 8'h10 + 8'(p)};
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Monitor: pops expected items on every DUT A request/response handshake.
   always @(negedge clk) begin
      req_t e;
      rsp_t r;
      if (!rst && a_out_valid && a_out_ready) begin
         if (req_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL req_unexpected: got tag %0h expected no request", a_out_tag);
         end else begin
            e = req_q.pop_front();
            chk("req", 64'({a_out_rw, a_out_addr, a_out_data, a_out_tag}), 64'(e));
         end
      end
      for (int p = 0; p < 4; p++) begin
         if (!rst && a_rsp_valid[p] && a_rsp_ready[p]) begin
            if (rsp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL rsp_unexpected: got port %0d expected no response", p);
            end else begin
               r = rsp_q.pop_front();
               chk("rsp", 64'({2'(p), a_rsp_tag, a_rsp_data}), 64'(r));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      a_req_valid = '0; a_req_rw = '0; a_rsp_ready = 4'hF; a_out_ready = 1'b1;
      a_l2_rsp_valid = 1'b0; a_l2_rsp_data = '0; a_l2_rsp_tag = '0;
      b_req_valid = '0; b_req_rw = '0; b_rsp_ready = 3'h7; b_out_ready = 1'b1;
      b_l2_rsp_valid = 1'b0; b_l2_rsp_data = '0; b_l2_rsp_tag = '0;
      for (int p = 0; p < 4; p++) begin
         a_req_byteen[p] = 4'hF;
         a_req_addr[p]   = 16'hA000 + 16'(p);
         a_req_data[p]   = 32'hD0D0_0000 + 32'(p);
         a_req_tag[p]    = 8'h10 + 8'(p);
      end
      for (int p = 0; p < 3; p++) begin
         b_req_byteen[p] = 4'hF;
         b_req_addr[p]   = 16'hB000 + 16'(p);
         b_req_data[p]   = 32'hBEEF_0000 + 32'(p);
         b_req_tag[p]    = 8'h40 + 8'(p);
      end

      // Reset state: requests present but nothing granted while rst is high.
      a_req_valid = 4'hF;
      tick();
      tick();
      @(negedge clk);
      chk("rst_ready", 64'(a_req_ready), 64'h0);
      chk("rst_out_valid", 64'(a_out_valid), 64'h0);
      chk("rst_err", 64'(a_err), 64'h0);
      tick();
      a_req_valid = '0;
      rst = 1'b0;
      tick();

      // Round-robin, full throughput, all ports reading.
      a_req_valid = 4'hF;
      for (int k = 0; k < 8; k++) begin
         req_q.push_back(exp_req(k % 4, 1'b0));
         @(negedge clk);
         chk("t1_rr_ready", 64'(a_req_ready), 64'(4'b0001 << (k % 4)));
         tick();
      end
      a_req_valid = '0;
      tick();
      tick();
      chk("t1_drained", 64'(req_q.size()), 64'h0);

      // Credit limit on port 2; writes bypass it.
      do_reset();
      a_req_valid = 4'b0100;
      for (int k = 0; k < 10; k++) begin
         if (k < 8) req_q.push_back(exp_req(2, 1'b0));
         @(negedge clk);
         chk("t2_credit", 64'(a_req_ready), (k < 8) ? 64'h4 : 64'h0);
         tick();
      end
      a_req_rw[2] = 1'b1;
      req_q.push_back(exp_req(2, 1'b1));
      @(negedge clk);
      chk("t2_write_pass", 64'(a_req_ready), 64'h4);
      tick();
      a_req_rw[2] = 1'b0;
      @(negedge clk);
      chk("t2_stall", 64'(a_req_ready), 64'h0);
      tick();
      a_l2_rsp_valid = 1'b1;
      a_l2_rsp_tag   = {2'd2, 8'h12};
      a_l2_rsp_data  = 32'hCAFE_0002;
      rsp_q.push_back(rsp_t'{port: 2'd2, tag: 8'h12, data: 32'hCAFE_0002});
      @(negedge clk);
      chk("t2_rsp_ready", 64'(a_l2_rsp_ready), 64'h1);
      chk("t2_rsp_valid", 64'(a_rsp_valid), 64'h4);
      chk("t2_same_cycle", 64'(a_req_ready), 64'h0);
      tick();
      a_l2_rsp_valid = 1'b0;
      req_q.push_back(exp_req(2, 1'b0));
      @(negedge clk);
      chk("t2_regrant", 64'(a_req_ready), 64'h4);
      tick();
      a_req_valid = '0;
      tick();
      tick();
      chk("t2_drained", 64'(req_q.size() + rsp_q.size()), 64'h0);

      // Back-pressure: payload held, no grants, pointer frozen.
      do_reset();
      a_out_ready = 1'b0;
      a_req_valid = 4'b0011;
      req_q.push_back(exp_req(0, 1'b0));
      @(negedge clk);
      chk("t3_first", 64'(a_req_ready), 64'h1);
      tick();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("t3_no_grant", 64'(a_req_ready), 64'h0);
         chk("t3_held", 64'({a_out_valid, a_out_addr, a_out_tag}), 64'({1'b1, 16'hA000, 2'd0, 8'h10}));
         tick();
      end
      a_out_ready = 1'b1;
      req_q.push_back(exp_req(1, 1'b0));
      @(negedge clk);
      chk("t3_rr_frozen", 64'(a_req_ready), 64'h2);
      tick();
      a_req_valid = '0;
      tick();
      tick();
      chk("t3_drained", 64'(req_q.size()), 64'h0);

      // Response back-pressure from port 1, then handshake.
      a_l2_rsp_valid = 1'b1;
      a_l2_rsp_tag   = {2'd1, 8'hA5};
      a_l2_rsp_data  = 32'h5A5A_0001;
      a_rsp_ready    = 4'b1101;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t4_rsp_stall", 64'({a_l2_rsp_ready, a_rsp_valid}), 64'({1'b0, 4'b0010}));
         tick();
      end
      a_rsp_ready = 4'hF;
      rsp_q.push_back(rsp_t'{port: 2'd1, tag: 8'hA5, data: 32'h5A5A_0001});
      @(negedge clk);
      chk("t4_rsp_hs", 64'(a_l2_rsp_ready), 64'h1);
      tick();
      a_l2_rsp_valid = 1'b0;
      tick();
      chk("t4_drained", 64'(rsp_q.size()), 64'h0);

      // DUT B: fixed priority starves port 2 until port 0 drops.
      b_req_rw    = 3'b111;
      b_req_valid = 3'b101;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t5_prio", 64'(b_req_ready), 64'h1);
         if (k > 0) chk("t5_out_port0", 64'(b_out_tag), 64'({2'd0, 8'h40}));
         tick();
      end
      b_req_valid = 3'b100;
      @(negedge clk);
      chk("t5_port2", 64'(b_req_ready), 64'h4);
      tick();
      b_req_valid = '0;
      @(negedge clk);
      chk("t5_out_port2", 64'({b_out_valid, b_out_rw, b_out_addr, b_out_tag}),
          64'({1'b1, 1'b1, 16'hB002, 2'd2, 8'h42}));
      tick();

      // DUT B: illegal response index is dropped and latched as an error.
      b_l2_rsp_valid = 1'b1;
      b_l2_rsp_tag   = {2'd3, 8'h77};
      b_l2_rsp_data  = 32'h0BAD_0BAD;
      b_rsp_ready    = 3'b000;
      @(negedge clk);
      chk("t6_drop", 64'({b_l2_rsp_ready, b_rsp_valid, b_err}), 64'({1'b1, 3'b000, 1'b0}));
      tick();
      b_l2_rsp_valid = 1'b0;
      @(negedge clk);
      chk("t6_err_set", 64'(b_err), 64'h1);
      tick();
      tick();
      @(negedge clk);
      chk("t6_err_sticky", 64'(b_err), 64'h1);
      tick();
      rst = 1'b1;
      tick();
      @(negedge clk);
      chk("t6_err_cleared", 64'(b_err), 64'h0);
      tick();
      rst = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
